spr_ram_arbiter: RTL and testbench



---
 rtl/spr_ram_arbiter_if.sv | 47 ++++
 rtl/spr_ram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_spr_ram_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spr_ram_arbiter_if.sv
// rtl/spr_ram_arbiter_if.sv - requester and RAM command signals for spr_ram_arbiter
interface spr_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                   req0_valid;
    logic                   req0_wr;
    logic [ADDR_SIZE-1:0]   req0_addr;
    logic [ADDR_SIZE-1:0]   req0_wdata;
    logic                   req0_ready;
    logic                   rsp0_valid;
    logic [ADDR_SIZE-1:0]   rsp0_rdata;
    logic                   rsp0_err;

    logic                   req1_valid;
    logic                   req1_wr;
    logic [ADDR_SIZE-1:0]   req1_addr;
    logic [ADDR_SIZE-1:0]   req1_wdata;
    logic                   req1_ready;
    logic                   rsp1_valid;
    logic [ADDR_SIZE-1:0]   rsp1_rdata;
    logic                   rsp1_err;

    logic [ADDR_SIZE+1:0]   ram_din;
    logic                   ram_rx_valid;
    logic [ADDR_SIZE-1:0]   ram_dout;
    logic                   ram_tx_valid;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output ram_din, ram_rx_valid,
        input  ram_dout, ram_tx_valid
    );

    // Requester / RAM side
    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  ram_din, ram_rx_valid,
        output ram_dout, ram_tx_valid
    );
endinterface

// File: rtl/spr_ram_arbiter.sv
// rtl/spr_ram_arbiter.sv - two-port round-robin arbiter and command sequencer for SPR_RAM
module spr_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    spr_ram_arbiter_if.slave   bus
);
    localparam int DW = ADDR_SIZE + 2;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_ADDR = 3'd1;
    localparam logic [2:0] S_W_DATA = 3'd2;
    localparam logic [2:0] S_R_ADDR = 3'd3;
    localparam logic [2:0] S_R_CMD  = 3'd4;
    localparam logic [2:0] S_R_WAIT = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 port_q, port_d;
    logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        din_q, din_d;
    logic                 rxv_q, rxv_d;
    logic [1:0]           rsp_valid_q, rsp_valid_d;
    logic [1:0]           rsp_err_q, rsp_err_d;
    logic [ADDR_SIZE-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [ADDR_SIZE-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic                 grant;
    logic                 accept;
    logic                 sel_wr;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [ADDR_SIZE-1:0] sel_wdata;
    logic                 rsp_fire;
    logic                 rsp_err;
    logic [ADDR_SIZE-1:0] rsp_data;

    // Round-robin pick: on a tie the port not served last wins; reset blocks acceptance
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        accept    = rst_n && (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_wr    = grant ? bus.req1_wr    : bus.req0_wr;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    // Sequencer: expands one accepted request into the RAM's two-step command and builds the response
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        din_d        = '0;
        rxv_d        = 1'b0;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    wdata_d      = sel_wdata;
                    rxv_d        = 1'b1;
                    if (sel_wr) begin
                        din_d   = {2'b00, sel_addr};
                        state_d = S_W_ADDR;
                    end else begin
                        din_d   = {2'b10, sel_addr};
                        state_d = S_R_ADDR;
                    end
                end
            end
            S_W_ADDR: begin
                din_d   = {2'b01, wdata_q};
                rxv_d   = 1'b1;
                state_d = S_W_DATA;
            end
            S_W_DATA: begin
                rsp_fire = 1'b1;
                state_d  = S_IDLE;
            end
            S_R_ADDR: begin
                din_d   = {2'b11, {ADDR_SIZE{1'b0}}};
                rxv_d   = 1'b1;
                state_d = S_R_CMD;
            end
            S_R_CMD: begin
                cnt_d   = '0;
                state_d = S_R_WAIT;
            end
            S_R_WAIT: begin
                if (bus.ram_tx_valid) begin
                    rsp_fire = 1'b1;
                    rsp_data = bus.ram_dout;
                    state_d  = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response steering: pulse valid on the issuing port only, data/err hold until its next response
    always_comb begin
        rsp_valid_d  = 2'b00;
        rsp_err_d    = rsp_err_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        if (rsp_fire) begin
            if (port_q) begin
                rsp_valid_d[1] = 1'b1;
                rsp_err_d[1]   = rsp_err;
                rsp1_rdata_d   = rsp_data;
            end else begin
                rsp_valid_d[0] = 1'b1;
                rsp_err_d[0]   = rsp_err;
                rsp0_rdata_d   = rsp_data;
            end
        end
    end

    // State and registered outputs; reset drops any in-flight access without a response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            din_q        <= '0;
            rxv_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            din_q        <= din_d;
            rxv_q        <= rxv_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign bus.ram_din      = din_q;
    assign bus.ram_rx_valid = rxv_q;
    assign bus.rsp0_valid   = rsp_valid_q[0];
    assign bus.rsp0_err     = rsp_err_q[0];
    assign bus.rsp0_rdata   = rsp0_rdata_q;
    assign bus.rsp1_valid   = rsp_valid_q[1];
    assign bus.rsp1_err     = rsp_err_q[1];
    assign bus.rsp1_rdata   = rsp1_rdata_q;
endmodule

// File: tb/tb_spr_ram_arbiter.sv
// tb/tb_spr_ram_arbiter.sv - self-checking bench for spr_ram_arbiter
module tb_spr_ram_arbiter;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spr_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

    spr_ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM stand-in: 00 latch write addr, 01 write data, 10 latch read addr, 11 return data next cycle
    bit [7:0] ram_mem [0:255];
    bit [7:0] ram_waddr;
    bit [7:0] ram_raddr;
    bit       ram_stub;

    always @(posedge clk) begin
        bus.ram_tx_valid <= 1'b0;
        if (bus.ram_rx_valid) begin
            case (bus.ram_din[9:8])
                2'b00: ram_waddr <= bus.ram_din[7:0];
                2'b01: ram_mem[ram_waddr] <= bus.ram_din[7:0];
                2'b10: ram_raddr <= bus.ram_din[7:0];
                default: begin
                    if (!ram_stub) begin
                        bus.ram_tx_valid <= 1'b1;
                        bus.ram_dout     <= ram_mem[ram_raddr];
                    end
                end
            endcase
        end
    end

    // Reference model: expected outputs scheduled by absolute cycle number
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_at = 0;
    bit last = 1'b1;
    bit [7:0] shadow [0:255];
    logic [9:0]  e_din   [int];
    bit          e_rxv   [int];
    logic [7:0]  e_rdata [int];
    bit          e_err   [int];
    logic [15:0] e_mw    [int];
    logic [7:0]  hold_d [2];
    bit          hold_e [2];

    bit       rq_v [2];
    bit       rq_w [2];
    bit [7:0] rq_a [2];
    bit [7:0] rq_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_cycle(output int g);
        bit rv [2];
        logic [7:0] a;
        bus.req0_valid = rq_v[0]; bus.req0_wr = rq_w[0]; bus.req0_addr = rq_a[0]; bus.req0_wdata = rq_d[0];
        bus.req1_valid = rq_v[1]; bus.req1_wr = rq_w[1]; bus.req1_addr = rq_a[1]; bus.req1_wdata = rq_d[1];
        @(negedge clk);
        g = -1;
        if (rst_n && cyc >= free_at && (rq_v[0] || rq_v[1]))
            g = (rq_v[0] && rq_v[1]) ? (last ? 0 : 1) : (rq_v[1] ? 1 : 0);
        for (int p = 0; p < 2; p++) begin
            rv[p] = e_rdata.exists(cyc * 2 + p);
            if (rv[p]) begin
                hold_d[p] = e_rdata[cyc * 2 + p];
                hold_e[p] = e_err[cyc * 2 + p];
            end
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        chk("ram_din", 32'(bus.ram_din), 32'(e_din.exists(cyc) ? e_din[cyc] : 10'h0));
        chk("ram_rx_valid", 32'(bus.ram_rx_valid), 32'(e_rxv.exists(cyc)));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(rv[0]));
        chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(hold_d[0]));
        chk("rsp0_err", 32'(bus.rsp0_err), 32'(hold_e[0]));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(rv[1]));
        chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(hold_d[1]));
        chk("rsp1_err", 32'(bus.rsp1_err), 32'(hold_e[1]));
        if (e_mw.exists(cyc)) shadow[e_mw[cyc][15:8]] = e_mw[cyc][7:0];
        if (g >= 0) begin
            a = rq_a[g];
            last = g[0];
            e_rxv[cyc + 1] = 1'b1;
            e_rxv[cyc + 2] = 1'b1;
            if (rq_w[g]) begin
                e_din[cyc + 1] = {2'b00, a};
                e_din[cyc + 2] = {2'b01, rq_d[g]};
                e_mw[cyc + 2]  = {a, rq_d[g]};
                e_rdata[(cyc + 3) * 2 + g] = 8'h00;
                e_err[(cyc + 3) * 2 + g]   = 1'b0;
                free_at = cyc + 3;
            end else begin
                e_din[cyc + 1] = {2'b10, a};
                e_din[cyc + 2] = {2'b11, 8'h00};
                if (!ram_stub) begin
                    e_rdata[(cyc + 4) * 2 + g] = shadow[a];
                    e_err[(cyc + 4) * 2 + g]   = 1'b0;
                    free_at = cyc + 4;
                end else begin
                    e_rdata[(cyc + 3 + TIMEOUT) * 2 + g] = 8'h00;
                    e_err[(cyc + 3 + TIMEOUT) * 2 + g]   = 1'b1;
                    free_at = cyc + 3 + TIMEOUT;
                end
            end
        end
        if (!rst_n) begin
            e_din.delete(); e_rxv.delete(); e_rdata.delete(); e_err.delete(); e_mw.delete();
            hold_d[0] = 8'h00; hold_d[1] = 8'h00; hold_e[0] = 1'b0; hold_e[1] = 1'b0;
            last = 1'b1;
            free_at = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) run_cycle(g);
    endtask

    // Present a request and hold it until the model says it is accepted (bounded)
    task automatic issue(input int p, input bit w, input bit [7:0] a, input bit [7:0] d);
        int g;
        rq_v[p] = 1'b1; rq_w[p] = w; rq_a[p] = a; rq_d[p] = d;
        for (int i = 0; i < 20; i++) begin
            run_cycle(g);
            if (g == p) break;
        end
        rq_v[p] = 1'b0;
    endtask

    initial begin
        int g;
        int grants;
        hold_d[0] = 8'h00; hold_d[1] = 8'h00; hold_e[0] = 1'b0; hold_e[1] = 1'b0;
        ram_stub = 1'b0;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b1; rq_w[p] = 1'b1; rq_a[p] = 8'h55; rq_d[p] = 8'h66;
        end
        @(posedge clk);
        #1;

        // Reset held with both ports requesting
        idle(3);
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Directed write then read-back from the other port
        issue(0, 1'b1, 8'h12, 8'hA5);
        idle(3);
        issue(1, 1'b0, 8'h12, 8'h00);
        idle(4);

        // Both ports request continuously for six accesses
        grants = 0;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b1; rq_w[p] = 1'($urandom); rq_a[p] = 8'($urandom_range(0, 7)); rq_d[p] = 8'($urandom);
        end
        for (int i = 0; i < 60 && grants < 6; i++) begin
            run_cycle(g);
            if (g >= 0) begin
                grants++;
                rq_w[g] = 1'($urandom); rq_a[g] = 8'($urandom_range(0, 7)); rq_d[g] = 8'($urandom);
            end
        end
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        idle(5);

        // Read timeout with the RAM never answering, then normal traffic resumes
        ram_stub = 1'b1;
        issue(0, 1'b0, 8'h03, 8'h00);
        idle(TIMEOUT + 4);
        ram_stub = 1'b0;
        issue(1, 1'b1, 8'h04, 8'h3C);
        idle(3);
        issue(0, 1'b0, 8'h04, 8'h00);
        idle(4);

        // Reset pulsed in W_DATA: no response, next access completes
        issue(0, 1'b1, 8'h05, 8'h77);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        issue(1, 1'b0, 8'h05, 8'h00);
        idle(4);

        // Random traffic with withdrawals
        for (int i = 0; i < 120; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq_v[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rq_v[p] = 1'b1; rq_w[p] = 1'($urandom);
                        rq_a[p] = 8'($urandom_range(0, 7)); rq_d[p] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    rq_v[p] = 1'b0;
                end
            end
            run_cycle(g);
            if (g >= 0) rq_v[g] = 1'b0;
        end
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
